// File: rtl/lif_neuron_scheduler_if.sv
// rtl/lif_neuron_scheduler_if.sv - current fetch and spike handshake bundle
interface lif_neuron_scheduler_if #(
    parameter int IDX_W   = 2,
    parameter int STATE_W = 8
);
    logic               cur_req;
    logic [IDX_W-1:0]   cur_idx;
    logic [STATE_W-1:0] cur_data;
    logic               cur_valid;
    logic               spike_valid;
    logic [IDX_W-1:0]   spike_idx;
    logic               spike_ready;

    modport master (
        output cur_req, cur_idx, spike_valid, spike_idx,
        input  cur_data, cur_valid, spike_ready
    );

    modport slave (
        input  cur_req, cur_idx, spike_valid, spike_idx,
        output cur_data, cur_valid, spike_ready
    );
endinterface

// File: rtl/lif_neuron_scheduler.sv
// rtl/lif_neuron_scheduler.sv - time-multiplexed LIF neuron update scheduler
module lif_neuron_scheduler #(
    parameter int N_NEURONS  = 4,
    parameter int STATE_W    = 8,
    parameter int THRESHOLD  = 200,
    parameter int LEAK_SHIFT = 1,
    parameter int REFRAC     = 2,
    localparam int IDX_W     = $clog2(N_NEURONS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    lif_neuron_scheduler_if.master  io,
    output logic                    busy,
    output logic                    done,
    input  logic [IDX_W-1:0]        rd_idx,
    output logic [STATE_W-1:0]      rd_state
);
    localparam int RW = (REFRAC < 1) ? 1 : $clog2(REFRAC + 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_UPDATE, S_EMIT, S_NEXT} fsm_t;

    fsm_t               fsm_q, fsm_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [STATE_W-1:0] cur_q, cur_d;
    logic [STATE_W-1:0] state_q  [N_NEURONS];
    logic [RW-1:0]      refrac_q [N_NEURONS];

    logic [STATE_W:0]   v_full;
    logic [STATE_W-1:0] v_sat;
    logic [STATE_W-1:0] st_new;
    logic [RW-1:0]      rf_new;
    logic               fire;
    logic               last;

    assign last = (idx_q == IDX_W'(N_NEURONS - 1));

    // Leak/integrate at one extra bit so the sum can be clamped instead of wrapping
    always_comb begin
        v_full = {1'b0, state_q[idx_q]} - {1'b0, state_q[idx_q] >> LEAK_SHIFT} + {1'b0, cur_q};
        v_sat  = v_full[STATE_W] ? '1 : v_full[STATE_W-1:0];
        fire   = 1'b0;
        st_new = v_sat;
        rf_new = '0;
        if (refrac_q[idx_q] != '0) begin
            st_new = '0;
            rf_new = refrac_q[idx_q] - RW'(1);
        end else if (int'(v_sat) >= THRESHOLD) begin
            fire   = 1'b1;
            st_new = '0;
            rf_new = RW'(REFRAC);
        end
    end

    always_comb begin
        fsm_d          = fsm_q;
        idx_d          = idx_q;
        cur_d          = cur_q;
        io.cur_req     = 1'b0;
        io.cur_idx     = idx_q;
        io.spike_valid = 1'b0;
        io.spike_idx   = idx_q;
        busy           = (fsm_q != S_IDLE);
        done           = 1'b0;
        case (fsm_q)
            S_IDLE: begin
                if (start) begin
                    fsm_d = S_FETCH;
                    idx_d = '0;
                end
            end
            S_FETCH: begin
                io.cur_req = 1'b1;
                if (io.cur_valid) begin
                    cur_d = io.cur_data;
                    fsm_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                fsm_d = fire ? S_EMIT : S_NEXT;
            end
            S_EMIT: begin
                io.spike_valid = 1'b1;
                if (io.spike_ready) begin
                    fsm_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (last) begin
                    done  = 1'b1;
                    fsm_d = S_IDLE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                    fsm_d = S_FETCH;
                end
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q <= S_IDLE;
            idx_q <= '0;
            cur_q <= '0;
        end else begin
            fsm_q <= fsm_d;
            idx_q <= idx_d;
            cur_q <= cur_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                state_q[i]  <= '0;
                refrac_q[i] <= '0;
            end
        end else if (fsm_q == S_UPDATE) begin
            state_q[idx_q]  <= st_new;
            refrac_q[idx_q] <= rf_new;
        end
    end

    assign rd_state = (int'(rd_idx) < N_NEURONS) ? state_q[rd_idx] : '0;
endmodule

// File: tb/tb_lif_neuron_scheduler.sv
// tb/tb_lif_neuron_scheduler.sv - self-checking bench for lif_neuron_scheduler
module tb_lif_neuron_scheduler;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TH = 200;
    localparam int LS = 1;
    localparam int RF = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         busy;
    logic         done;
    logic [1:0]   rd_idx;
    logic [W-1:0] rd_state;

    int tests = 0;
    int fails = 0;
    int m_state  [N];
    int m_refrac [N];
    int cur_tab  [N];
    int exp_sp   [$];

    lif_neuron_scheduler_if #(.IDX_W(2), .STATE_W(W)) ifc ();

    lif_neuron_scheduler #(
        .N_NEURONS(N), .STATE_W(W), .THRESHOLD(TH), .LEAK_SHIFT(LS), .REFRAC(RF)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .io(ifc),
        .busy(busy), .done(done), .rd_idx(rd_idx), .rd_state(rd_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One timestep of every neuron, straight from the leak/integrate/fire rules
    task automatic model_sweep();
        int v;
        exp_sp.delete();
        for (int n = 0; n < N; n++) begin
            if (m_refrac[n] != 0) begin
                m_state[n]  = 0;
                m_refrac[n] = m_refrac[n] - 1;
            end else begin
                v = m_state[n] - m_state[n] / (2 ** LS) + cur_tab[n];
                if (v > 2 ** W - 1) v = 2 ** W - 1;
                if (v >= TH) begin
                    exp_sp.push_back(n);
                    m_state[n]  = 0;
                    m_refrac[n] = RF;
                end else begin
                    m_state[n] = v;
                end
            end
        end
    endtask

    task automatic check_states();
        for (int n = 0; n < N; n++) begin
            rd_idx = 2'(n);
            #1;
            chk($sformatf("rd_state[%0d]", n), rd_state, m_state[n]);
        end
    endtask

    task automatic sweep(input int st_lo, input int st_hi, input int bp_lo, input int bp_hi,
                         input int abort_idx);
        int cyc = 0, stall, bp, extra = 0, fetch_n = 0, hold = -1;
        bit got_done = 0, arm_abort = 0, aborted = 0;
        int got_sp [$];
        if (abort_idx < 0) model_sweep();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        stall = $urandom_range(st_lo, st_hi);
        bp    = $urandom_range(bp_lo, bp_hi);
        while (!got_done && !aborted && cyc < 1000) begin
            ifc.cur_valid   = 1'b0;
            ifc.spike_ready = 1'b0;
            ifc.cur_data    = W'($urandom);
            if (arm_abort) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                for (int n = 0; n < N; n++) begin
                    m_state[n]  = 0;
                    m_refrac[n] = 0;
                end
                aborted = 1;
            end else begin
                if (ifc.cur_req) begin
                    chk("cur_idx", ifc.cur_idx, fetch_n);
                    if (stall > 0) begin
                        stall--;
                        extra++;
                    end else begin
                        ifc.cur_valid = 1'b1;
                        ifc.cur_data  = W'(cur_tab[fetch_n]);
                        if (fetch_n == abort_idx) arm_abort = 1;
                        fetch_n++;
                        stall = $urandom_range(st_lo, st_hi);
                    end
                end
                if (ifc.spike_valid) begin
                    if (hold < 0) begin
                        hold = int'(ifc.spike_idx);
                        chk("spike_idx_cur", ifc.spike_idx, fetch_n - 1);
                    end else begin
                        chk("spike_hold", ifc.spike_idx, hold);
                    end
                    if (bp > 0) begin
                        bp--;
                        extra++;
                    end else begin
                        ifc.spike_ready = 1'b1;
                        got_sp.push_back(hold);
                        hold = -1;
                        bp   = $urandom_range(bp_lo, bp_hi);
                    end
                end
                if (done) begin
                    got_done = 1;
                    chk("done_cycle", cyc, 3 * N + exp_sp.size() + extra);
                    start = 1'b1;
                end
                @(negedge clk);
                cyc++;
            end
        end
        start           = 1'b0;
        ifc.cur_valid   = 1'b0;
        ifc.spike_ready = 1'b0;
        if (!aborted) begin
            if (!got_done) chk("sweep_timeout", 0, 1);
            chk("busy_after_done", busy, 0);
            chk("done_one_cycle", done, 0);
            chk("spike_count", got_sp.size(), exp_sp.size());
            for (int i = 0; i < got_sp.size() && i < exp_sp.size(); i++)
                chk("spike_order", got_sp[i], exp_sp[i]);
        end
        check_states();
    endtask

    initial begin
        rst             = 1'b1;
        start           = 1'b0;
        rd_idx          = 2'd0;
        ifc.cur_data    = '0;
        ifc.cur_valid   = 1'b0;
        ifc.spike_ready = 1'b0;
        for (int n = 0; n < N; n++) begin
            m_state[n]  = 0;
            m_refrac[n] = 0;
            cur_tab[n]  = 0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cur_req", ifc.cur_req, 0);
        chk("rst_spike_valid", ifc.spike_valid, 0);
        chk("rst_cur_idx", ifc.cur_idx, 0);
        chk("rst_spike_idx", ifc.spike_idx, 0);
        check_states();

        sweep(0, 0, 0, 0, -1);

        cur_tab = '{120, 0, 0, 0};
        sweep(0, 0, 0, 0, -1);
        rd_idx = 2'd0; #1; chk("n0_step1", rd_state, 120);
        sweep(0, 0, 0, 0, -1);
        rd_idx = 2'd0; #1; chk("n0_step2", rd_state, 180);
        sweep(0, 0, 0, 0, -1);
        rd_idx = 2'd0; #1; chk("n0_step3", rd_state, 0);

        cur_tab = '{255, 0, 0, 0};
        repeat (3) sweep(0, 0, 0, 0, -1);
        rd_idx = 2'd0; #1; chk("n0_refrac_refire", m_refrac[0], RF);

        cur_tab = '{0, 120, 0, 0};
        repeat (2) sweep(0, 0, 0, 0, -1);
        cur_tab = '{0, 255, 0, 0};
        sweep(0, 0, 0, 0, -1);
        chk("sat_fire_model", exp_sp.size(), 1);

        cur_tab = '{0, 0, 210, 0};
        sweep(0, 0, 5, 5, -1);

        cur_tab = '{50, 60, 70, 80};
        sweep(3, 3, 0, 0, 3);

        for (int k = 0; k < 30; k++) begin
            for (int n = 0; n < N; n++) cur_tab[n] = $urandom_range(0, 255);
            sweep(0, 2, 0, 3, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
